// File: rtl/simon_pkg.sv
// simon_pkg: shared constants, FSM state codes and bit-level helpers for the
// SIMON 128/256 core (simon_128256) and its key-expansion unit.
//   N     word width (block = 2N)
//   M     key words
//   T     rounds / round keys
//   CO    round-counter width
//   ZLEN  length of the z4 constant sequence
//   Z4    z4 sequence, bit j = z4[j]
package simon_pkg;

  localparam int N    = 64;
  localparam int M    = 4;
  localparam int T    = 72;
  localparam int CO   = 7;
  localparam int ZLEN = 62;

  // Bit j of this constant is element j of the z4 sequence.
  localparam logic [ZLEN-1:0] Z4 = 62'h3DC94C3A046D678B;

  // State codes are exported on the mode port, so the values are fixed.
  typedef enum logic [3:0] {
    ST_IDLE   = 4'd0,
    ST_KEYEXP = 4'd1,
    ST_LOAD   = 4'd2,
    ST_ROUND  = 4'd3,
    ST_DONE   = 4'd4
  } state_t;

  function automatic logic [N-1:0] rol(input logic [N-1:0] x, input int s);
    return (x << s) | (x >> (N - s));
  endfunction

  function automatic logic [N-1:0] ror(input logic [N-1:0] x, input int s);
    return (x >> s) | (x << (N - s));
  endfunction

  // SIMON round function.
  function automatic logic [N-1:0] f(input logic [N-1:0] x);
    return (rol(x, 1) & rol(x, 8)) ^ rol(x, 2);
  endfunction

endpackage

// File: rtl/simon_key_expand.sv
// simon_key_expand: round-key store and key schedule for SIMON 128/256.
// i_load captures the M key words into k[0..M-1] and restarts the schedule;
// each i_step cycle then derives one further round key until all T exist.
// Ports:
//   clk, rst  clock, asynchronous active-high reset (clears the whole store)
//   i_load    capture i_key (k0 = i_key[N-1:0]), clear o_done
//   i_key     M*N key words
//   i_step    derive the next round key (ignored once o_done is set)
//   i_idx     round-key read index
//   o_rk      k[i_idx]
//   o_last    the pending step produces the final round key
//   o_done    all T round keys valid
module simon_key_expand
  import simon_pkg::*;
(
  input  logic            clk,
  input  logic            rst,
  input  logic            i_load,
  input  logic [M*N-1:0]  i_key,
  input  logic            i_step,
  input  logic [CO-1:0]   i_idx,
  output logic [N-1:0]    o_rk,
  output logic            o_last,
  output logic            o_done
);

  logic [N-1:0]    r_k [T];
  logic [CO-1:0]   r_cnt;   // i: the step in flight writes k[i+M]
  logic            r_done;

  logic [N-1:0]    w_t;
  logic [N-1:0]    w_new;
  logic [5:0]      w_zi;

  always_comb begin
    w_zi  = (r_cnt >= CO'(ZLEN)) ? 6'(r_cnt - CO'(ZLEN)) : 6'(r_cnt);
    w_t   = ror(r_k[r_cnt + CO'(3)], 3) ^ r_k[r_cnt + CO'(1)];
    w_t   = w_t ^ ror(w_t, 1);
    // ~k ^ 3 is the schedule constant c = 2^N - 4 folded into k[i].
    w_new = ~r_k[r_cnt] ^ w_t ^ {{(N-1){1'b0}}, Z4[w_zi]} ^ N'(3);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < T; i++) r_k[i] <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_load) begin
      for (int i = 0; i < M; i++) r_k[i] <= i_key[i*N +: N];
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else if (i_step && !r_done) begin
      r_k[r_cnt + CO'(M)] <= w_new;
      if (o_last) r_done <= 1'b1;
      else        r_cnt  <= r_cnt + CO'(1);
    end
  end

  assign o_rk   = r_k[i_idx];
  assign o_last = (r_cnt == CO'(T - M - 1));
  assign o_done = r_done;

endmodule

// File: rtl/simon_128256.sv
// simon_128256: iterative SIMON 128/256 block cipher, one round per clock.
// Host handshake: newKey/newData are level requests held by the host; the
// core acknowledges capture with a one-cycle loadKey/loadData pulse, after
// which the host may drop the request. doneKey/doneData are level flags; a
// result on outData stays valid until the host asserts readData for a cycle.
// Ports:
//   clk       rising-edge clock
//   nR        asynchronous active-high reset
//   newData   block request, inData/enc_dec valid
//   newKey    key request, key valid (priority over newData in IDLE)
//   enc_dec   1 = encrypt, 0 = decrypt, sampled in LOAD
//   readData  host consumed outData
//   inData    block {x, y}
//   key       {k3, k2, k1, k0}
//   loadData  inData captured (pulse)
//   loadKey   key captured (pulse)
//   doneData  outData valid
//   doneKey   round keys valid
//   outData   result {x, y}
//   mode      current FSM state code
module simon_128256
  import simon_pkg::*;
(
  input  logic            clk,
  input  logic            nR,
  input  logic            newData,
  input  logic            newKey,
  input  logic            enc_dec,
  input  logic            readData,
  input  logic [2*N-1:0]  inData,
  input  logic [M*N-1:0]  key,
  output logic            loadData,
  output logic            loadKey,
  output logic            doneData,
  output logic            doneKey,
  output logic [2*N-1:0]  outData,
  output logic [3:0]      mode
);

  state_t          r_state;
  state_t          w_next;

  logic [N-1:0]    r_x;
  logic [N-1:0]    r_y;
  logic            r_enc;
  logic [CO-1:0]   r_cnt;
  logic            r_load_data;
  logic            r_load_key;
  logic            r_done_data;
  logic [2*N-1:0]  r_out;

  logic            w_kx_load;
  logic            w_kx_step;
  logic            w_kx_last;
  logic            w_done_key;
  logic [CO-1:0]   w_rk_idx;
  logic [N-1:0]    w_rk;
  logic            w_last_round;
  logic [N-1:0]    w_x_nxt;
  logic [N-1:0]    w_y_nxt;

  simon_key_expand u_kx (
    .clk    (clk),
    .rst    (nR),
    .i_load (w_kx_load),
    .i_key  (key),
    .i_step (w_kx_step),
    .i_idx  (w_rk_idx),
    .o_rk   (w_rk),
    .o_last (w_kx_last),
    .o_done (w_done_key)
  );

  // Next-state logic.
  always_comb begin
    w_next    = r_state;
    w_kx_load = 1'b0;
    w_kx_step = 1'b0;
    unique case (r_state)
      ST_IDLE: begin
        if (newKey) begin
          w_kx_load = 1'b1;
          w_next    = ST_KEYEXP;
        end else if (newData && w_done_key) begin
          w_next = ST_LOAD;
        end
      end
      ST_KEYEXP: begin
        w_kx_step = 1'b1;
        if (w_kx_last) w_next = ST_IDLE;
      end
      ST_LOAD:  w_next = ST_ROUND;
      ST_ROUND: if (w_last_round) w_next = ST_DONE;
      ST_DONE:  if (readData) w_next = ST_IDLE;
      default:  w_next = ST_IDLE;
    endcase
  end

  // Round datapath; decryption walks the key store backwards.
  always_comb begin
    w_last_round = (r_cnt == CO'(T - 1));
    w_rk_idx     = r_enc ? r_cnt : (CO'(T - 1) - r_cnt);
    if (r_enc) begin
      w_x_nxt = r_y ^ f(r_x) ^ w_rk;
      w_y_nxt = r_x;
    end else begin
      w_x_nxt = r_y;
      w_y_nxt = r_x ^ f(r_y) ^ w_rk;
    end
  end

  always_ff @(posedge clk or posedge nR) begin
    if (nR) r_state <= ST_IDLE;
    else    r_state <= w_next;
  end

  always_ff @(posedge clk or posedge nR) begin
    if (nR) begin
      r_x         <= '0;
      r_y         <= '0;
      r_enc       <= 1'b0;
      r_cnt       <= '0;
      r_load_data <= 1'b0;
      r_load_key  <= 1'b0;
      r_done_data <= 1'b0;
      r_out       <= '0;
    end else begin
      r_load_key  <= w_kx_load;
      r_load_data <= (r_state == ST_LOAD);
      case (r_state)
        ST_LOAD: begin
          r_x   <= inData[2*N-1:N];
          r_y   <= inData[N-1:0];
          r_enc <= enc_dec;
          r_cnt <= '0;
        end
        ST_ROUND: begin
          r_x   <= w_x_nxt;
          r_y   <= w_y_nxt;
          r_cnt <= r_cnt + CO'(1);
          if (w_last_round) begin
            r_out       <= {w_x_nxt, w_y_nxt};
            r_done_data <= 1'b1;
          end
        end
        ST_DONE: if (readData) r_done_data <= 1'b0;
        default: ;
      endcase
    end
  end

  assign loadData = r_load_data;
  assign loadKey  = r_load_key;
  assign doneData = r_done_data;
  assign doneKey  = w_done_key;
  assign outData  = r_out;
  assign mode     = r_state;

endmodule

// File: tb/tb_simon_128256.sv
// tb_simon_128256: bench for simon_128256. Reference model computes SIMON
// 128/256 directly from the cipher definition (z4 taken from its bit string).
module tb_simon_128256;

  logic          clk = 1'b0;
  logic          nR;
  logic          newData, newKey, enc_dec, readData;
  logic [127:0]  inData;
  logic [255:0]  key;
  logic          loadData, loadKey, doneData, doneKey;
  logic [127:0]  outData;
  logic [3:0]    mode;

  int            n_checks = 0;
  int            n_errors = 0;
  logic [127:0]  exp_q[$];

  localparam logic [255:0] KAT_KEY = 256'h1F1E1D1C1B1A1918_1716151413121110_0F0E0D0C0B0A0908_0706050403020100;
  localparam logic [127:0] KAT_PT  = 128'h74206E69206D6F6F_6D69732061207369;
  localparam logic [127:0] KAT_CT  = 128'h8D2B5579AFC8A3A0_3BF72A87EFE7B868;

  typedef struct {
    logic [255:0] key;
    logic         enc;
    logic [127:0] din;
    logic [127:0] dout;
  } vec_t;

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  simon_128256 dut (
    .clk      (clk),
    .nR       (nR),
    .newData  (newData),
    .newKey   (newKey),
    .enc_dec  (enc_dec),
    .readData (readData),
    .inData   (inData),
    .key      (key),
    .loadData (loadData),
    .loadKey  (loadKey),
    .doneData (doneData),
    .doneKey  (doneKey),
    .outData  (outData),
    .mode     (mode)
  );

  // ---------------- reference model ----------------
  function automatic logic [63:0] rot_left(input logic [63:0] v, input int s);
    logic [63:0] r;
    for (int j = 0; j < 64; j++) r[(j + s) % 64] = v[j];
    return r;
  endfunction

  function automatic logic [63:0] mf(input logic [63:0] v);
    return (rot_left(v, 1) & rot_left(v, 8)) ^ rot_left(v, 2);
  endfunction

  function automatic logic [127:0] model_crypt(input logic [255:0] k, input logic [127:0] blk, input logic enc);
    string       zs;
    logic [63:0] rk [72];
    logic [63:0] x, y, t;
    zs = "11010001111001101011011000100000010111000011001010010011101111";
    for (int i = 0; i < 4; i++) rk[i] = k[64*i +: 64];
    for (int i = 0; i < 68; i++) begin
      t = rot_left(rk[i+3], 61) ^ rk[i+1];     // ROR3
      t = t ^ rot_left(t, 63);                  // ^= ROR1
      rk[i+4] = ~rk[i] ^ t ^ 64'd3 ^ ((zs[i % 62] == 8'h31) ? 64'd1 : 64'd0);
    end
    x = blk[127:64];
    y = blk[63:0];
    if (enc) begin
      for (int r = 0; r < 72; r++) begin
        t = x; x = y ^ mf(x) ^ rk[r]; y = t;
      end
    end else begin
      for (int r = 71; r >= 0; r--) begin
        t = y; y = x ^ mf(y) ^ rk[r]; x = t;
      end
    end
    return {x, y};
  endfunction

  function automatic logic [127:0] rnd128();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // ---------------- checker ----------------
  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- driver tasks (all start and end just after a negedge) ----------------
  task automatic do_reset();
    nR = 1'b1; newData = 1'b0; newKey = 1'b0; readData = 1'b0;
    enc_dec = 1'b0; inData = '0; key = '0;
    repeat (2) @(negedge clk);
    nR = 1'b0;
    @(negedge clk);
  endtask

  task automatic load_key(input logic [255:0] k);
    int n;
    bit seen;
    key = k; newKey = 1'b1;
    seen = 1'b0;
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      if (loadKey) begin seen = 1'b1; break; end
    end
    newKey = 1'b0;
    check("loadkey_pulse", 128'(seen), 128'(1));
    check("donekey_low_kexp", 128'(doneKey), 128'(0));
    check("mode_kexp", 128'(mode), 128'(1));
    @(negedge clk);
    n = 1;
    check("loadkey_one_cycle", 128'(loadKey), 128'(0));
    while (!doneKey && n < 200) begin @(negedge clk); n++; end
    check("kexp_cycles", 128'(n), 128'(68));
  endtask

  // Runs one block; poke drives newKey briefly during ROUND, which must be ignored.
  task automatic run_block(input logic [127:0] din, input logic enc, input int hold,
                           input bit poke, output logic [127:0] res);
    int n;
    bit seen;
    inData = din; enc_dec = enc; newData = 1'b1;
    seen = 1'b0;
    for (n = 0; n < 8; n++) begin
      @(negedge clk);
      if (loadData) begin seen = 1'b1; break; end
    end
    newData = 1'b0;
    inData  = rnd128();   // must not be re-sampled mid-block
    enc_dec = ~enc;
    check("loaddata_pulse", 128'(seen), 128'(1));
    n = 0;
    while (!doneData && n < 200) begin
      newKey = (poke && n < 5);
      if (poke) key = '0;
      @(negedge clk);
      n++;
    end
    newKey = 1'b0;
    check("latency", 128'(n), 128'(72));
    if (poke) check("donekey_kept", 128'(doneKey), 128'(1));
    res = outData;
    for (int h = 0; h < hold; h++) begin
      @(negedge clk);
      check("donedata_hold", 128'(doneData), 128'(1));
      check("out_stable", outData, res);
    end
    readData = 1'b1;
    @(negedge clk);
    readData = 1'b0;
    check("donedata_fall", 128'(doneData), 128'(0));
    check("mode_idle", 128'(mode), 128'(0));
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #2000000;
    n_errors++;
    $display("FAIL watchdog: time limit reached");
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  // ---------------- test sequence ----------------
  initial begin
    vec_t         vecs [6];
    logic [255:0] cur_key, rkey, key_a;
    logic [127:0] res, pt [5], ct [5];
    bit           saw;

    rkey = {rnd128(), rnd128()};
    vecs[0] = '{KAT_KEY, 1'b1, KAT_PT, KAT_CT};
    vecs[1] = '{KAT_KEY, 1'b0, KAT_CT, KAT_PT};
    for (int i = 2; i < 6; i++) begin
      vecs[i].key  = (i < 4) ? KAT_KEY : rkey;
      vecs[i].enc  = logic'(i % 2);
      vecs[i].din  = rnd128();
      vecs[i].dout = model_crypt(vecs[i].key, vecs[i].din, vecs[i].enc);
    end

    // Reset state
    do_reset();
    check("rst_out", outData, 128'(0));
    check("rst_flags", 128'({loadData, loadKey, doneData, doneKey}), 128'(0));
    check("rst_mode", 128'(mode), 128'(0));

    // newData without a key must wait in IDLE
    inData = KAT_PT; enc_dec = 1'b1; newData = 1'b1;
    saw = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (loadData || mode != 4'd0) saw = 1'b1;
    end
    newData = 1'b0;
    check("nokey_no_load", 128'(saw), 128'(0));

    // Vector table
    cur_key = '0;
    for (int i = 0; i < 6; i++) begin
      if (i == 0 || vecs[i].key != cur_key) begin
        load_key(vecs[i].key);
        cur_key = vecs[i].key;
      end
      exp_q.push_back(vecs[i].dout);
      run_block(vecs[i].din, vecs[i].enc, $urandom_range(0, 4), (i == 0), res);
      check($sformatf("vec%0d", i), res, exp_q.pop_front());
    end

    // Stream round trip across a reset
    pt[0] = 128'hA8D5F7DE0123FEDC_01234567FEDCBA98;
    pt[1] = 128'h5BC92D014567BA98_89ABCDEF01234567;
    for (int i = 2; i < 5; i++) pt[i] = rnd128();
    load_key(rkey);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(model_crypt(rkey, pt[i], 1'b1));
      run_block(pt[i], 1'b1, $urandom_range(0, 2), 1'b0, ct[i]);
      check($sformatf("stream_enc%0d", i), ct[i], exp_q.pop_front());
    end
    do_reset();
    check("stream_rst_donekey", 128'(doneKey), 128'(0));
    load_key(rkey);
    for (int i = 0; i < 5; i++) begin
      exp_q.push_back(pt[i]);
      run_block(ct[i], 1'b0, 0, 1'b0, res);
      check($sformatf("stream_dec%0d", i), res, exp_q.pop_front());
    end

    // Reset during ROUND
    load_key(KAT_KEY);
    inData = KAT_PT; enc_dec = 1'b1; newData = 1'b1;
    repeat (3) @(negedge clk);
    newData = 1'b0;
    repeat (30) @(negedge clk);
    check("midrst_in_round", 128'(mode), 128'(3));
    #2 nR = 1'b1;
    #1;
    check("midrst_out", outData, 128'(0));
    check("midrst_flags", 128'({loadData, loadKey, doneData, doneKey}), 128'(0));
    check("midrst_mode", 128'(mode), 128'(0));
    @(negedge clk);
    nR = 1'b0;
    @(negedge clk);
    load_key(KAT_KEY);
    run_block(KAT_PT, 1'b1, 1, 1'b0, res);
    check("midrst_kat", res, KAT_CT);

    // Key change: key A then all-zero key B
    key_a = {rnd128(), rnd128()};
    load_key(key_a);
    load_key('0);
    pt[0] = rnd128();
    exp_q.push_back(model_crypt('0, pt[0], 1'b1));
    run_block(pt[0], 1'b1, 0, 1'b0, res);
    check("keychange_b", res, exp_q.pop_front());

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
